butterfly_inv: RTL
==================

Name: butterfly_inv

Overview:
- Inverse radix-2 butterfly for the 8-point FFT datapath: recovers operand pair (a, b) from butterfly outputs s = a+b and d = a-b, as a = (s+d)/2 and b = (s-d)/2.
- Uses one shared add/sub datapath, time-multiplexed by a small FSM: add pass, then subtract pass.
- Sits on the IFFT/unscramble side of the add/sub butterfly stage.
- Valid/ready handshake on both input and output.

Parameters:
- N, 3, log2 of data width; data width W = 2**N (default 8 bits).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  s/d pair valid
- in_ready  output  1  block can accept a pair
- s  input  W  butterfly sum operand, unsigned
- d  input  W  butterfly difference operand, unsigned
- out_valid  output  1  a/b/odd valid
- out_ready  input  1  downstream accepts result
- a  output  W  recovered first operand
- b  output  W  recovered second operand
- odd  output  1  (s+d) was odd, so the pair is not a consistent butterfly pair (low bit lost)
- busy  output  1  FSM not in IDLE

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - in_ready=1, out_valid=0, a=0, b=0, odd=0, busy=0.
  - Operand registers are cleared.
  - Reset asserted mid-operation aborts the pair in flight; nothing is emitted after release.
- FSM states:
  - IDLE: in_ready=1. If in_valid=1, capture s and d into registers and go to ADD.
  - ADD: shared unit in add mode; compute 9-bit (W+1) sum = {0,s}+{0,d}. Register a = sum[W:1] and odd = sum[0]. Go to SUB.
  - SUB: shared unit in subtract mode; compute W+1-bit two's-complement diff = {0,s}-{0,d}. Register b = diff[W:1] (arithmetic halving; negative results appear as two's complement, e.g. -1 becomes 0xFF). Go to DONE.
  - DONE: out_valid=1 and a/b/odd are held stable. If out_ready=1, return to IDLE (out_valid drops next cycle). Otherwise stay in DONE.
- Handshake and latency:
  - in_ready=1 only in IDLE; s/d are ignored in all other states.
  - Input transfer occurs on a rising edge where in_valid and in_ready are both 1.
  - out_valid rises 3 cycles after the accepting edge.
  - Output transfer occurs on an edge where out_valid and out_ready are both 1.
  - Throughput: at most one pair per 4 cycles, since there is no overlap. A new pair is accepted on the cycle after the output handshake.
  - in_valid and out_ready may both be high continuously; pairs are then processed back-to-back at 4 cycles each.
- Arithmetic:
  - Internal width is W+1 so the carry/borrow is never lost before halving.
  - Outputs are truncated to W bits.
  - s and d must not be modified inside the block after capture.
- Boundary conditions:
  - s=d=0 gives all-zero outputs.
  - s=d=2^W-1 gives a=2^W-1, b=0 (carry retained).
  - s<d gives a negative b, encoded as two's complement.
- Registers: busy=1 in ADD/SUB/DONE. a, b and odd change only in ADD/SUB and are held otherwise.

Test Plan:
- Reset, then s=12, d=4, out_ready=1 -> out_valid on the 3rd cycle after accept; a=8, b=4, odd=0; in_ready low for 4 cycles.
- s=3, d=5 -> a=4, b=255 (two's complement -1), odd=0.
- s=7, d=2 -> a=4, b=2, odd=1.
- s=255, d=255 -> a=255, b=0, odd=0 (carry preserved).
- Backpressure: s=20, d=10 with out_ready=0 for 5 cycles -> out_valid held, a=15, b=5 stable; in_ready=0 and a second in_valid pair is ignored until the handshake.
- Reset mid-ADD with s=100, d=50 -> all outputs 0 immediately; after release, no out_valid; next pair s=6, d=2 -> a=4, b=2.

Source files
------------

// File: rtl/butterfly_inv.sv
// Inverse radix-2 butterfly: recovers (a, b) from s = a+b and d = a-b using one
// shared add/sub unit sequenced over an add pass and a subtract pass.
module butterfly_inv #(
  parameter int unsigned N = 3,
  localparam int unsigned W = 2 ** N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] s,
  input  logic [W-1:0] d,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic         odd,
  output logic         busy
);

  localparam int unsigned WP = W + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] SUB  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]   state_q;
  logic [1:0]   state_d;
  logic         capture;
  logic         sub_mode;
  logic         load_a;
  logic         load_b;
  logic [W-1:0] s_q;
  logic [W-1:0] d_q;
  logic [WP-1:0] s_ext;
  logic [WP-1:0] d_ext;
  logic [WP-1:0] opnd;
  logic [WP-1:0] res;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    sub_mode = 1'b0;
    load_a   = 1'b0;
    load_b   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          capture = 1'b1;
          state_d = ADD;
        end
      end
      ADD: begin
        load_a  = 1'b1;
        state_d = SUB;
      end
      SUB: begin
        sub_mode = 1'b1;
        load_b   = 1'b1;
        state_d  = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shared adder; subtraction is add of the one's complement plus carry-in
  always_comb begin
    s_ext = {1'b0, s_q};
    d_ext = {1'b0, d_q};
    opnd  = sub_mode ? ~d_ext : d_ext;
    res   = s_ext + opnd + WP'(sub_mode);
  end

  // Operand capture and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= '0;
      d_q <= '0;
      a   <= '0;
      b   <= '0;
      odd <= 1'b0;
    end else begin
      if (capture) begin
        s_q <= s;
        d_q <= d;
      end
      if (load_a) begin
        a   <= res[WP-1:1];
        odd <= res[0];
      end
      if (load_b) begin
        b <= res[WP-1:1];
      end
    end
  end

  // Handshake/status flags registered from the next state so they track state_q
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      busy      <= (state_d != IDLE);
    end
  end

endmodule
